oled_spi_receiver: RTL
======================

Name: oled_spi_receiver

Overview:
- Receive-side model of the 4-wire OLED SPI link driven by screen_driver (io_sclk/io_sdin/io_cs/io_dc/io_reset).
- Deserialises bytes MSB-first and decodes the SSD1306 command subset the driver emits.
- Turns data bytes into framebuffer writes using the same 10-bit {page,column} index as pixelIndex.
- Used as an on-FPGA loopback/capture target and as the panel model in simulation.

Parameters:
SYNC_INPUTS, 1, 1 = pass all io_* inputs through a 2-flop synchroniser; 0 = sample directly (same-clock source only)
COLS, 128, panel width in columns; fixes column pointer width at 7 bits
PAGES, 8, panel height in 8-pixel pages; fixes page pointer width at 3 bits

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
io_sclk  in  1  SPI clock; data sampled on its rising edge
io_sdin  in  1  SPI data, MSB first
io_cs  in  1  chip select, active low
io_dc  in  1  0 = command byte, 1 = data byte
io_reset  in  1  panel reset, active low
fb_we  out  1  one-cycle framebuffer write strobe
fb_addr  out  10  write address {page[2:0], col[6:0]}
fb_wdata  out  8  write data (bit0 = top pixel of page)
cmd_valid  out  1  one-cycle strobe per received command-mode byte (including arguments)
cmd_byte  out  8  byte qualified by cmd_valid
display_on  out  1  set by 0xAF, cleared by 0xAE
frame_done  out  1  one-cycle pulse when the write pointer wraps the full window

Behaviour:
- Reset: rst_n low at a clk edge clears all outputs to 0, display_on=0, col=0, page=0, window to col 0..127 and page 0..7, bit counter=0, parser=P_CMD. Synchronised io_reset low has the same effect.
- Sampling:
  - Inputs are registered (2 stages if SYNC_INPUTS=1).
  - A rising edge is detected when sclk_q=1 and sclk_prev=0.
  - sclk high and low phases must each be at least 1 clk with SYNC_INPUTS=0, and at least 3 clk with SYNC_INPUTS=1.
- Shift: on each detected rising edge with cs_q=0, shift sdin_q into the byte register and increment a 3-bit counter. On the 8th bit, latch dc_q and the byte. The bit counter clears whenever cs_q=1, so a partial byte is discarded with no strobe.
- Latency: fb_we or cmd_valid asserts exactly 1 clk after the cycle in which the 8th edge is detected, for 1 clk.
- Command byte (dc=0): cmd_valid=1 and cmd_byte=byte, then the parser acts on it.
  - P_CMD, 0x21: go to P_COL_S. 0x22: go to P_PAGE_S. 0xAF/0xAE: set/clear display_on.
  - P_CMD, 0x20, 0x81, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D: go to P_SKIP (1 argument).
  - P_CMD, any other byte: no effect.
  - P_COL_S: col_start=byte[6:0], col=col_start, go to P_COL_E.
  - P_COL_E: col_end=byte[6:0], go to P_CMD.
  - P_PAGE_S: page_start=byte[2:0], page=page_start, go to P_PAGE_E.
  - P_PAGE_E: page_end=byte[2:0], go to P_CMD.
  - P_SKIP: ignore the byte, go to P_CMD.
  - Start values are committed immediately. If collection is aborted before the end byte arrives, col_end/page_end keep their old values.
- Data byte (dc=1):
  - Any pending argument state aborts to P_CMD.
  - fb_we=1, fb_addr={page,col}, fb_wdata=byte.
- Pointer advance after each data write:
  - If col==col_end: col=col_start; then if page==page_end, page=page_start and frame_done=1 (same cycle as fb_we), else page=page+1 (3-bit wrap).
  - Otherwise col=col+1 (7-bit wrap 127→0).
  - If start>end, the pointer wraps modulo width until it reaches end.
- fb_we and cmd_valid are never asserted in the same cycle.
- Only horizontal addressing is modelled; the 0x20 argument is consumed and ignored.

Test Plan:
- Init: dc=0 bytes AE,D5,80,A8,3F,8D,14,AF → 8 cmd_valid pulses with bytes in order; display_on=1 after AF; no fb_we; parser returns to P_CMD.
- Full frame: 21,00,7F,22,00,07, then 1024 data bytes = index[7:0] → fb_addr 0..1023 in order with wdata=addr[7:0]; exactly one frame_done, coincident with addr 1023; the next write goes to addr 0.
- Window: 21,10,13 and 22,02,03, then 10 data bytes → addrs 0x110-0x113, 0x190-0x193, 0x110, 0x111; frame_done on the 8th write only.
- Abort: cs low, 5 clocks of bits, cs high, then full byte 0xA5 dc=1 → a single fb_we with wdata=A5 at current pointer.
- Arg abort: 21,20 (dc=0) then data 0x55 → write at col 0x20 page 0; col_end is still 0x7F.
- Reset: rst_n low (then separately io_reset low) mid-byte and mid-frame → all outputs 0, display_on=0, next data byte writes addr 0.

Source files
------------

// File: rtl/oled_spi_receiver.sv
// Receive side of the 4-wire OLED SPI link.
// - Deserialises MSB-first bytes.
// - Decodes the SSD1306 command subset the screen driver emits.
// - Turns data bytes into {page,column} framebuffer writes.
module oled_spi_receiver #(
    parameter int SYNC_INPUTS = 1,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_sclk,
    input  logic       io_sdin,
    input  logic       io_cs,
    input  logic       io_dc,
    input  logic       io_reset,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_wdata,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       display_on,
    output logic       frame_done
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    // Idle levels for {sclk, sdin, cs, dc, reset}: chip deselected, panel out of reset.
    localparam logic [4:0] IN_IDLE = 5'b00101;

    typedef enum logic [2:0] {
        P_CMD,
        P_COL_S,
        P_COL_E,
        P_PAGE_S,
        P_PAGE_E,
        P_SKIP
    } pstate_t;

    logic [4:0] in_raw;
    logic [4:0] s1_q;
    logic [4:0] in_q;
    logic       sclk_q, sdin_q, cs_q, dc_q, reset_q;
    logic       sclk_prev_q;
    logic       srst;

    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       bit_en;
    logic       byte_done;
    logic [7:0] byte_w;

    pstate_t    state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] col_start_q, col_start_d;
    logic [CW-1:0] col_end_q, col_end_d;
    logic [PW-1:0] page_q, page_d;
    logic [PW-1:0] page_start_q, page_start_d;
    logic [PW-1:0] page_end_q, page_end_d;

    logic       fb_we_q, fb_we_d;
    logic [9:0] fb_addr_q, fb_addr_d;
    logic [7:0] fb_wdata_q, fb_wdata_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic       display_on_q, display_on_d;
    logic       frame_done_q, frame_done_d;

    assign in_raw = {io_sclk, io_sdin, io_cs, io_dc, io_reset};

    // First input register stage; always present.
    always_ff @(posedge clk) begin
        if (!rst_n) s1_q <= IN_IDLE;
        else        s1_q <= in_raw;
    end

    generate
        if (SYNC_INPUTS != 0) begin : g_sync
            logic [4:0] s2_q;
            // Second stage completes the synchroniser for asynchronous sources.
            always_ff @(posedge clk) begin
                if (!rst_n) s2_q <= IN_IDLE;
                else        s2_q <= s1_q;
            end
            assign in_q = s2_q;
        end else begin : g_nosync
            assign in_q = s1_q;
        end
    endgenerate

    assign {sclk_q, sdin_q, cs_q, dc_q, reset_q} = in_q;

    // Delayed copy of sclk for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) sclk_prev_q <= 1'b0;
        else        sclk_prev_q <= sclk_q;
    end

    // The panel reset pin acts exactly like the system reset on the core state.
    assign srst      = !rst_n || !reset_q;
    assign bit_en    = sclk_q && !sclk_prev_q && !cs_q;
    assign byte_done = bit_en && (bit_cnt_q == 3'd7);
    assign byte_w    = {shift_q, sdin_q};

    // Shift register and bit counter; deselect discards any partial byte.
    always_ff @(posedge clk) begin
        if (srst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (cs_q) begin
            bit_cnt_q <= '0;
        end else if (bit_en) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            shift_q   <= byte_w[6:0];
        end
    end

    // Parser state register.
    always_ff @(posedge clk) begin
        if (srst) state_q <= P_CMD;
        else      state_q <= state_d;
    end

    // Parser next state: track which argument byte, if any, is expected next.
    always_comb begin
        state_d = state_q;
        if (byte_done) begin
            if (dc_q) begin
                state_d = P_CMD;
            end else begin
                case (state_q)
                    P_CMD: begin
                        case (byte_w)
                            8'h21: state_d = P_COL_S;
                            8'h22: state_d = P_PAGE_S;
                            8'h20, 8'h81, 8'hA8, 8'hD3, 8'hD5,
                            8'hD9, 8'hDA, 8'hDB, 8'h8D: state_d = P_SKIP;
                            default: state_d = P_CMD;
                        endcase
                    end
                    P_COL_S:  state_d = P_COL_E;
                    P_COL_E:  state_d = P_CMD;
                    P_PAGE_S: state_d = P_PAGE_E;
                    P_PAGE_E: state_d = P_CMD;
                    P_SKIP:   state_d = P_CMD;
                    default:  state_d = P_CMD;
                endcase
            end
        end
    end

    // Parser outputs: command side effects, framebuffer write and pointer advance.
    always_comb begin
        col_d        = col_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_d       = page_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        display_on_d = display_on_q;
        frame_done_d = 1'b0;
        if (byte_done && !dc_q) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_w;
            case (state_q)
                P_CMD: begin
                    if (byte_w == 8'hAF)      display_on_d = 1'b1;
                    else if (byte_w == 8'hAE) display_on_d = 1'b0;
                end
                P_COL_S: begin
                    col_start_d = byte_w[CW-1:0];
                    col_d       = byte_w[CW-1:0];
                end
                P_COL_E:  col_end_d = byte_w[CW-1:0];
                P_PAGE_S: begin
                    page_start_d = byte_w[PW-1:0];
                    page_d       = byte_w[PW-1:0];
                end
                P_PAGE_E: page_end_d = byte_w[PW-1:0];
                default: ;
            endcase
        end else if (byte_done && dc_q) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = {page_q, col_q};
            fb_wdata_d = byte_w;
            if (col_q == col_end_q) begin
                col_d = col_start_q;
                if (page_q == page_end_q) begin
                    page_d       = page_start_q;
                    frame_done_d = 1'b1;
                end else begin
                    page_d = page_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            col_q        <= '0;
            col_start_q  <= '0;
            col_end_q    <= CW'(COLS - 1);
            page_q       <= '0;
            page_start_q <= '0;
            page_end_q   <= PW'(PAGES - 1);
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            display_on_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_q       <= page_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            display_on_q <= display_on_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign display_on = display_on_q;
    assign frame_done = frame_done_q;

endmodule
